backing_memory: RTL and testbench

Word-addressed backing store that acts as the responder on the cache-to-memory request interface: the data-memory front end drives address, read/write enables and write data, and this block answers after a fixed, parameterised latency with read data and a response flag. It replaces the zero-wait-state temporary memory in system simulations. It lets the front end's miss, fill and write-back paths be exercised against realistic multi-cycle memory timing.

---
 rtl/backing_memory.sv | 93 +++++++++
 tb/tb_backing_memory.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/backing_memory.sv
// Word-addressed backing store answering the cache-to-memory request interface
// after a fixed LATENCY, with a 4-phase response handshake.
module backing_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_write_val,
  output logic [31:0] mem_read_val,
  output logic        mem_response
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state, state_next;
  logic [7:0]            count;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  op_write;
  logic [31:0]           wdata;
  logic [31:0]           mem [2**ADDR_WIDTH];
  logic                  accept, complete, release_resp;

  // Upper address bits alias onto the same words.
  logic unused_addr;
  assign unused_addr = ^mem_addr[31:ADDR_WIDTH];

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    complete     = 1'b0;
    release_resp = 1'b0;
    case (state)
      IDLE: if (mem_read_en || mem_write_en) begin
        accept     = 1'b1;
        state_next = BUSY;
      end
      BUSY: if (count == 8'd0) begin
        complete   = 1'b1;
        state_next = DONE;
      end
      DONE: if (!mem_read_en && !mem_write_en) begin
        release_resp = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count        <= 8'd0;
      idx          <= '0;
      op_write     <= 1'b0;
      wdata        <= 32'd0;
      mem_read_val <= 32'd0;
      mem_response <= 1'b0;
    end else begin
      if (accept) begin
        idx      <= mem_addr[ADDR_WIDTH-1:0];
        op_write <= mem_write_en;  // write wins when both enables are high
        wdata    <= mem_write_val;
        count    <= 8'(LATENCY - 1);
      end else if (state == BUSY && count != 8'd0) begin
        count <= count - 8'd1;
      end
      if (complete) begin
        mem_response <= 1'b1;
        if (!op_write) mem_read_val <= mem[idx];
      end
      if (release_resp) mem_response <= 1'b0;
    end
  end

  // NOTE: the array is deliberately not reset; contents survive rst, and an
  // interrupted write never reaches it because rst forces the FSM to IDLE.
  always_ff @(posedge clk) begin
    if (complete && op_write) mem[idx] <= wdata;
  end

endmodule

// File: tb/tb_backing_memory.sv
// Randomized scoreboard bench for backing_memory: a driver issues requests and
// queues expected responses; a monitor checks them when mem_response rises.
module tb_backing_memory;

  localparam int ADDR_WIDTH = 8;
  localparam int LATENCY    = 4;
  localparam int WORDS      = 2**ADDR_WIDTH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr = '0;
  logic        mem_read_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [31:0] mem_write_val = '0;
  logic [31:0] mem_read_val;
  logic        mem_response;

  backing_memory #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_write_val(mem_write_val),
    .mem_read_val (mem_read_val),
    .mem_response (mem_response)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] val;  // mem_read_val expected while the response is high
    int          cyc;  // acceptance edge number
  } exp_t;

  exp_t sb[$];

  // Reference model: plain word array plus the last value a read returned.
  logic [31:0] model_mem [WORDS];
  bit          written   [WORDS];
  int          waddrs[$];
  logic [31:0] model_rd = '0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: compare each rising response against the head of the scoreboard.
  initial begin
    logic resp_prev;
    exp_t e;
    resp_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_response && !resp_prev) begin
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("resp_cycle", 32'(cycle), 32'(e.cyc + LATENCY));
          check("read_val", mem_read_val, e.val);
        end
      end
      resp_prev = mem_response;
    end
  end

  task automatic drop_enables();
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with it idle.
  task automatic do_txn(input bit we, input bit re, input logic [31:0] addr,
                        input logic [31:0] data, input int hold, input bit drop_early);
    exp_t e;
    int   n;
    int   w;
    mem_addr      = addr;
    mem_write_en  = we;
    mem_read_en   = re;
    mem_write_val = data;
    e.cyc = cycle + 1;
    w = int'(addr[ADDR_WIDTH-1:0]);
    if (we) begin
      model_mem[w] = data;
      if (!written[w]) begin
        written[w] = 1'b1;
        waddrs.push_back(w);
      end
    end else begin
      model_rd = model_mem[w];
    end
    e.val = model_rd;
    sb.push_back(e);

    if (drop_early) begin
      @(negedge clk);
      drop_enables();
      repeat (LATENCY) @(negedge clk);
      check("pulse_high", 32'(mem_response), 32'd1);
      @(negedge clk);
      check("pulse_low", 32'(mem_response), 32'd0);
    end else begin
      n = 0;
      while (!mem_response && n < LATENCY + 10) begin
        @(negedge clk);
        n++;
        if (!mem_response) begin
          mem_addr      = $urandom;
          mem_write_val = $urandom;
        end
      end
      check("resp_seen", 32'(mem_response), 32'd1);
      repeat (hold) begin
        @(negedge clk);
        check("resp_hold", 32'(mem_response), 32'd1);
      end
      drop_enables();
      @(negedge clk);
      check("resp_fall", 32'(mem_response), 32'd0);
    end
  endtask

  initial begin
    int          r;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_resp", 32'(mem_response), 32'd0);
    check("reset_rdval", mem_read_val, 32'd0);

    // First write with enables held beyond the response.
    do_txn(1'b1, 1'b0, 32'd3, 32'h11, 2, 1'b0);

    for (int i = 0; i < 8; i++) do_txn(1'b1, 1'b0, 32'(i), 32'(i + 1), i % 3, 1'b0);
    for (int i = 0; i < 8; i++) do_txn(1'b0, 1'b1, 32'(i), 32'd0, i % 2, 1'b0);

    // Both enables high is a write.
    do_txn(1'b1, 1'b1, 32'd5, 32'hAA, 0, 1'b0);
    do_txn(1'b0, 1'b1, 32'd5, 32'd0, 0, 1'b0);

    // Aliasing through ignored upper address bits.
    do_txn(1'b1, 1'b0, 32'h105, 32'h99, 0, 1'b0);
    do_txn(1'b0, 1'b1, 32'h005, 32'd0, 0, 1'b0);

    // Enables dropped early, then a back-to-back request.
    do_txn(1'b0, 1'b1, 32'd2, 32'd0, 0, 1'b1);
    do_txn(1'b0, 1'b1, 32'd7, 32'd0, 0, 1'b0);

    // Reset during a pending write discards it.
    do_txn(1'b1, 1'b0, 32'd2, 32'h55, 0, 1'b0);
    do_txn(1'b0, 1'b1, 32'd2, 32'd0, 0, 1'b0);
    mem_addr      = 32'd2;
    mem_write_en  = 1'b1;
    mem_write_val = 32'h77;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_resp", 32'(mem_response), 32'd0);
    check("midrst_rdval", mem_read_val, 32'd0);
    drop_enables();
    @(negedge clk);
    rst      = 1'b0;
    model_rd = '0;
    do_txn(1'b0, 1'b1, 32'd2, 32'd0, 0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 3));
      if (r < 2 || waddrs.size() == 0) begin
        do_txn(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom,
               int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0);
      end else begin
        a = 32'(waddrs[$urandom_range(0, waddrs.size() - 1)]) | ($urandom & 32'hFFFF_FF00);
        do_txn(1'b0, 1'b1, a, 32'd0, int'($urandom_range(0, 2)), $urandom_range(0, 7) == 0);
      end
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
